// File: rtl/divisor_pkg.sv
// Shared constants for the restoring divider: quotient-register commands and controller
// state encodings. Also imported by the quotient shift register.
package divisor_pkg;

    localparam logic [1:0] Q_CMD_HOLD = 2'b00;
    localparam logic [1:0] Q_CMD_ZERO = 2'b10;
    localparam logic [1:0] Q_CMD_ONE  = 2'b01;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_ITER = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    function automatic logic [1:0] q_cmd_for(input logic q_bit);
        return q_bit ? Q_CMD_ONE : Q_CMD_ZERO;
    endfunction

endpackage

// File: rtl/divisor_step.sv
// One combinational restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module divisor_step #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] r,
    input  logic         dvd_msb,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] r_next,
    output logic         q_bit
);

    logic [N:0]   t;
    logic [N-1:0] diff;

    always_comb begin
        t      = {r, dvd_msb};
        q_bit  = (t >= {1'b0, divisor});
        // When the subtraction is taken the true result is below the divisor, so N bits suffice.
        diff   = t[N-1:0] - divisor;
        r_next = q_bit ? diff : t[N-1:0];
    end

endmodule

// File: rtl/divisor_control.sv
// Sequencing controller for the restoring divider: one quotient command per step, MSB first.
// Optional build macro DIVISOR_CONTROL_ZERO_CHECK_EN short-circuits divide-by-zero with div_err.
module divisor_control
    import divisor_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4   // 2**CW must exceed N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         q_clr,
    output logic [1:0]   q_cmd,
    output logic [N-1:0] remainder,
    output logic         done,
    output logic         div_err
);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  dsr_q, dsr_d;
    logic [N-1:0]  r_q, r_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          q_clr_q, q_clr_d;
    logic [1:0]    q_cmd_q, q_cmd_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          done_q, done_d;

    logic [N-1:0]  step_r;
    logic [N-1:0]  step_r_next;
    logic          step_q;

    // The step leaving LOAD starts from a zero remainder, so each command is registered in the
    // same cycle the controller shows ITER.
    assign step_r = (state_q == ST_LOAD) ? '0 : r_q;

    divisor_step #(
        .N (N)
    ) u_step (
        .r       (step_r),
        .dvd_msb (dvd_q[N-1]),
        .divisor (dsr_q),
        .r_next  (step_r_next),
        .q_bit   (step_q)
    );

`ifdef DIVISOR_CONTROL_ZERO_CHECK_EN
    logic err_q, err_d;
    assign div_err = err_q;
`else
    assign div_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        r_d         = r_q;
        count_d     = count_q;
        ready_d     = 1'b0;
        q_clr_d     = 1'b0;
        q_cmd_d     = Q_CMD_HOLD;
        remainder_d = remainder_q;
        done_d      = 1'b0;
`ifdef DIVISOR_CONTROL_ZERO_CHECK_EN
        err_d       = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    state_d = ST_LOAD;
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    ready_d = 1'b0;
                    q_clr_d = 1'b1;
`ifdef DIVISOR_CONTROL_ZERO_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end

            ST_LOAD: begin
`ifdef DIVISOR_CONTROL_ZERO_CHECK_EN
                if (dsr_q == '0) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    remainder_d = dvd_q;
                end else begin
                    state_d = ST_ITER;
                    r_d     = step_r_next;
                    dvd_d   = dvd_q << 1;
                    count_d = '0;
                    q_cmd_d = q_cmd_for(step_q);
                end
`else
                state_d = ST_ITER;
                r_d     = step_r_next;
                dvd_d   = dvd_q << 1;
                count_d = '0;
                q_cmd_d = q_cmd_for(step_q);
`endif
            end

            ST_ITER: begin
                if (count_q == CW'(N - 1)) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    remainder_d = r_q;
                end else begin
                    r_d     = step_r_next;
                    dvd_d   = dvd_q << 1;
                    count_d = count_q + CW'(1);
                    q_cmd_d = q_cmd_for(step_q);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            r_q         <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            q_clr_q     <= 1'b0;
            q_cmd_q     <= Q_CMD_HOLD;
            remainder_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            r_q         <= r_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            q_clr_q     <= q_clr_d;
            q_cmd_q     <= q_cmd_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
        end
    end

`ifdef DIVISOR_CONTROL_ZERO_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign ready     = ready_q;
    assign q_clr     = q_clr_q;
    assign q_cmd     = q_cmd_q;
    assign remainder = remainder_q;
    assign done      = done_q;

endmodule

// File: tb/tb_divisor_control.sv
// Directed-vector bench for divisor_control (N=8): command sequences, latency, start
// filtering, back-to-back runs, mid-run reset and divide-by-zero.
module tb_divisor_control;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       ready;
    logic       q_clr;
    logic [1:0] q_cmd;
    logic [7:0] remainder;
    logic       done;
    logic       div_err;

    int vectors;
    int miscompares;

    // Trace of the most recent run, cycle numbers relative to the accepting edge (edge 0).
    int         clr_cyc, done_cyc, first_cmd, ncmd, bad_cmd, ready_hi;
    logic [7:0] qval, rem_s;
    logic       err_s;

    divisor_control #(
        .N  (8),
        .CW (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .q_clr     (q_clr),
        .q_cmd     (q_cmd),
        .remainder (remainder),
        .done      (done),
        .div_err   (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Records one run; start is high while c < hold_until or at cycles pa/pb.
    task automatic capture(input int base, input int hold_until, input int pa, input int pb,
                           input logic [7:0] na, input logic [7:0] nb);
        clr_cyc = -1; done_cyc = -1; first_cmd = -1; ncmd = 0; bad_cmd = 0; ready_hi = 0;
        qval = '0; rem_s = '0; err_s = 1'b0;
        for (int c = 1; c <= 16 && done_cyc < 0; c++) begin
            @(negedge clk);
            start = (c < hold_until) || (c == pa) || (c == pb);
            if (c == 1) begin
                dividend = na;
                divisor  = nb;
            end
            if (ready && c >= 2) ready_hi++;
            if (q_clr && clr_cyc < 0) clr_cyc = base + c;
            if (q_cmd == 2'b11) begin
                bad_cmd++;
            end else if (q_cmd != 2'b00) begin
                if (first_cmd < 0) first_cmd = base + c;
                ncmd++;
                qval = {qval[6:0], (q_cmd == 2'b01)};
            end
            if (done) begin
                done_cyc = base + c;
                rem_s    = remainder;
                err_s    = div_err;
            end
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({ready, q_clr, q_cmd, done, div_err} !== 6'b100000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 100000", {ready, q_clr, q_cmd, done, div_err});
        end
        vectors++;
        if (remainder !== 8'd0) begin
            miscompares++; $display("FAIL reset_rem: got %0d want 0", remainder);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_div_100_7;
        launch(8'd100, 8'd7);
        capture(0, 1, -1, -1, 8'd55, 8'd3);
        vectors++;
        if (clr_cyc !== 1) begin miscompares++; $display("FAIL d100_clr: got %0d want 1", clr_cyc); end
        vectors++;
        if (first_cmd !== 2) begin
            miscompares++; $display("FAIL d100_first_cmd: got %0d want 2", first_cmd);
        end
        vectors++;
        if (ncmd !== 8) begin miscompares++; $display("FAIL d100_ncmd: got %0d want 8", ncmd); end
        vectors++;
        if (qval !== 8'd14) begin miscompares++; $display("FAIL d100_quot: got %0d want 14", qval); end
        vectors++;
        if (done_cyc !== 10) begin
            miscompares++; $display("FAIL d100_done: got %0d want 10", done_cyc);
        end
        vectors++;
        if (rem_s !== 8'd2) begin miscompares++; $display("FAIL d100_rem: got %0d want 2", rem_s); end
        vectors++;
        if (err_s !== 1'b0) begin miscompares++; $display("FAIL d100_err: got %0d want 0", err_s); end
        vectors++;
        if (bad_cmd !== 0 || ready_hi !== 0) begin
            miscompares++;
            $display("FAIL d100_busy: got bad=%0d rdy=%0d want 0 0", bad_cmd, ready_hi);
        end
        @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL d100_ready_after: got %0d want 1", ready); end
    endtask

    task automatic test_extremes;
        launch(8'd255, 8'd1);
        capture(0, 1, -1, -1, 8'd0, 8'd0);
        vectors++;
        if (ncmd !== 8 || qval !== 8'd255) begin
            miscompares++; $display("FAIL d255_1_quot: got n=%0d q=%0d want 8 255", ncmd, qval);
        end
        vectors++;
        if (rem_s !== 8'd0) begin miscompares++; $display("FAIL d255_1_rem: got %0d want 0", rem_s); end
        launch(8'd5, 8'd9);
        capture(0, 1, -1, -1, 8'd200, 8'd1);
        vectors++;
        if (ncmd !== 8 || qval !== 8'd0) begin
            miscompares++; $display("FAIL d5_9_quot: got n=%0d q=%0d want 8 0", ncmd, qval);
        end
        vectors++;
        if (rem_s !== 8'd5) begin miscompares++; $display("FAIL d5_9_rem: got %0d want 5", rem_s); end
    endtask

    task automatic test_start_ignored;
        launch(8'd100, 8'd7);
        capture(0, 1, 3, 6, 8'd1, 8'd1);
        vectors++;
        if (clr_cyc !== 1 || ncmd !== 8 || qval !== 8'd14) begin
            miscompares++;
            $display("FAIL busy_start_seq: got clr=%0d n=%0d q=%0d want 1 8 14", clr_cyc, ncmd, qval);
        end
        vectors++;
        if (done_cyc !== 10 || rem_s !== 8'd2) begin
            miscompares++;
            $display("FAIL busy_start_res: got done=%0d rem=%0d want 10 2", done_cyc, rem_s);
        end
    endtask

    task automatic test_back_to_back;
        launch(8'd100, 8'd7);
        capture(0, 999, -1, -1, 8'd200, 8'd3);
        vectors++;
        if (done_cyc !== 10 || qval !== 8'd14 || rem_s !== 8'd2) begin
            miscompares++;
            $display("FAIL b2b_first: got done=%0d q=%0d rem=%0d want 10 14 2", done_cyc, qval, rem_s);
        end
        capture(10, 3, -1, -1, 8'd200, 8'd3);
        vectors++;
        if (clr_cyc !== 12) begin miscompares++; $display("FAIL b2b_clr: got %0d want 12", clr_cyc); end
        vectors++;
        if (first_cmd !== 13 || ncmd !== 8 || qval !== 8'd66) begin
            miscompares++;
            $display("FAIL b2b_cmds: got first=%0d n=%0d q=%0d want 13 8 66", first_cmd, ncmd, qval);
        end
        vectors++;
        if (done_cyc !== 21 || rem_s !== 8'd2) begin
            miscompares++;
            $display("FAIL b2b_second: got done=%0d rem=%0d want 21 2", done_cyc, rem_s);
        end
        vectors++;
        if (bad_cmd !== 0 || ready_hi !== 0) begin
            miscompares++;
            $display("FAIL b2b_busy: got bad=%0d rdy=%0d want 0 0", bad_cmd, ready_hi);
        end
    endtask

    task automatic test_reset_mid_run;
        launch(8'd100, 8'd7);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (q_cmd !== 2'b10) begin miscompares++; $display("FAIL mid_cmd_c5: got %b want 10", q_cmd); end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (q_cmd !== 2'b00 || ready !== 1'b1 || remainder !== 8'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got cmd=%b rdy=%0d rem=%0d done=%0d want 00 1 0 0",
                     q_cmd, ready, remainder, done);
        end
        @(negedge clk);
        reset = 1'b1;
        launch(8'd9, 8'd3);
        capture(0, 1, -1, -1, 8'd0, 8'd0);
        vectors++;
        if (clr_cyc !== 1 || done_cyc !== 10 || qval !== 8'd3 || rem_s !== 8'd0) begin
            miscompares++;
            $display("FAIL after_reset_9_3: got clr=%0d done=%0d q=%0d rem=%0d want 1 10 3 0",
                     clr_cyc, done_cyc, qval, rem_s);
        end
    endtask

    task automatic test_divide_by_zero;
        launch(8'd42, 8'd0);
        capture(0, 1, -1, -1, 8'd9, 8'd9);
`ifdef DIVISOR_CONTROL_ZERO_CHECK_EN
        vectors++;
        if (clr_cyc !== 1 || done_cyc !== 2 || ncmd !== 0) begin
            miscompares++;
            $display("FAIL dz_timing: got clr=%0d done=%0d n=%0d want 1 2 0", clr_cyc, done_cyc, ncmd);
        end
        vectors++;
        if (err_s !== 1'b1 || rem_s !== 8'd42) begin
            miscompares++; $display("FAIL dz_result: got err=%0d rem=%0d want 1 42", err_s, rem_s);
        end
        launch(8'd100, 8'd7);
        capture(0, 1, -1, -1, 8'd0, 8'd0);
        vectors++;
        if (err_s !== 1'b0 || rem_s !== 8'd2) begin
            miscompares++; $display("FAIL dz_clear: got err=%0d rem=%0d want 0 2", err_s, rem_s);
        end
`else
        vectors++;
        if (done_cyc !== 10 || ncmd !== 8 || qval !== 8'd255) begin
            miscompares++;
            $display("FAIL dz_run: got done=%0d n=%0d q=%0d want 10 8 255", done_cyc, ncmd, qval);
        end
        vectors++;
        if (err_s !== 1'b0 || rem_s !== 8'd42) begin
            miscompares++; $display("FAIL dz_result: got err=%0d rem=%0d want 0 42", err_s, rem_s);
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        dividend    = '0;
        divisor     = '0;
        test_reset;
        test_div_100_7;
        test_extremes;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid_run;
        test_divide_by_zero;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/divisor_control.md
Name: divisor_control

Overview:
- Sequencing controller for the restoring divider datapath.
- Each run performs N compare/subtract steps and keeps the partial remainder internally.
- Each step issues one 2-bit quotient-bit command to the external quotient shift register (salida-style `i_a` input).
- Sits between the top-level operand source and the quotient register, with a start/ready/done handshake.

Parameters:
- N, 8, operand width; also the number of iterations.
- CW, 4, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a division; sampled only when ready=1.
- dividend  in  N  dividend operand, captured on accepted start.
- divisor  in  N  divisor operand, captured on accepted start.
- ready  out  1  controller idle and able to accept start.
- q_clr  out  1  one-cycle clear pulse to the quotient register.
- q_cmd  out  2  quotient command: 00 hold, 10 shift-in 0, 01 shift-in 1.
- remainder  out  N  final remainder, held until the next accepted start.
- done  out  1  one-cycle pulse when the result is valid.
- div_err  out  1  divide-by-zero flag, valid with done.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, ready=1.
  - q_clr=0, q_cmd=00, done=0, div_err=0.
  - remainder=0, internal regs=0.
- States: IDLE, LOAD, ITER, DONE. All outputs are registered.
- IDLE:
  - ready=1.
  - start=1 latches dividend/divisor into internal regs and goes to LOAD.
  - start is ignored in every other state (no queueing).
- LOAD (1 cycle):
  - ready=0, q_clr=1.
  - partial remainder r<=0, count<=0.
  - Next state: ITER.
- ITER (exactly N cycles):
  - t = {r, dvd[N-1]}, N+1 bits wide, so no overflow.
  - If t >= {1'b0, divisor}: r <= t - divisor, q_cmd=01.
  - Otherwise: r <= t[N-1:0], q_cmd=10.
  - dvd <<= 1, count++.
  - After count reaches N-1, go to DONE.
- DONE (1 cycle):
  - done=1, remainder<=r, q_cmd=00.
  - Next state: IDLE, with ready=1 on the following cycle.
- q_cmd=00 in every state except ITER; q_cmd is never 11.
- Latency: start sampled at edge 0, then q_clr at cycle 1, q_cmd at cycles 2..N+1, done at cycle N+2. Throughput is one division per N+3 cycles.
- Back-to-back: start held high is accepted again on the first IDLE cycle after DONE.
- Operands may change after acceptance without affecting the run in progress.
- Reset mid-operation:
  - Immediate return to IDLE with reset values.
  - q_cmd drops to 00 asynchronously; the partial quotient is left to the datapath.
- Quotient MSB is issued first (MSB-first order, matching the left-shift quotient register).

Optional Feature:
- Macro: DIVISOR_CONTROL_ZERO_CHECK_EN.
- Defined:
  - In LOAD, divisor==0 skips ITER and goes directly to DONE.
  - div_err=1 with done; remainder=dividend; no q_cmd pulses (quotient stays 0 after q_clr).
  - done at cycle 2.
  - div_err clears at the next accepted start.
- Not defined:
  - div_err is tied to 0.
  - Divide-by-zero runs normally: all N commands are 01 (quotient all ones) and remainder=dividend.

Decomposition:
- Package divisor_pkg:
  - Q_CMD_HOLD=2'b00, Q_CMD_ZERO=2'b10, Q_CMD_ONE=2'b01.
  - State encoding constants for IDLE/LOAD/ITER/DONE.
  - Shared with the quotient register.
- Sub-module divisor_step:
  - Purely combinational, one restoring step.
  - Inputs: r, dividend MSB, divisor. Outputs: next r, quotient bit.
  - Controller instantiates it once.

Test Plan:
- 100/7, N=8:
  - q_clr at cycle 1.
  - q_cmd over cycles 2..9 = 10,10,10,10,01,01,01,10 (quotient 14).
  - done at cycle 10, remainder=2, div_err=0.
- 255/1: eight consecutive 01 commands, remainder=0. 5/9: eight 10 commands, remainder=5.
- start pulsed again at cycles 3 and 6 during 100/7: ignored; command sequence and result unchanged.
- start held high across two runs (100/7 then 200/3): second q_clr at cycle 12; second result remainder=2 with quotient commands for 66.
- reset=0 at cycle 5 of a run: q_cmd=00, ready=1, remainder=0 immediately. A subsequent 9/3 run completes with remainder=0.
- 42/0:
  - With macro: done at cycle 2, div_err=1, remainder=42, no 01/10 commands.
  - Without macro: eight 01 commands, remainder=42, div_err=0.
